// File: rtl/gcd_pkg.sv
// Shared types and default sizing for the GCD scheduler slice.
package gcd_pkg;

  localparam int GCD_W = 16;
  localparam int GCD_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Requester index width; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_sched_if.sv
// Request/response bundle between requesters, the result consumer and gcd_sched.
interface gcd_sched_if #(
  parameter int W = gcd_pkg::GCD_W,
  parameter int N = gcd_pkg::GCD_N
);
  import gcd_pkg::*;

  localparam int IW = idx_w(N);

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_gcd;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_steps;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_gcd, rsp_id, rsp_steps
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_gcd, rsp_id, rsp_steps
  );

endinterface

// File: rtl/gcd_core.sv
// Subtractive GCD datapath: one swap, subtract or done-detect per step.
module gcd_core #(
  parameter int W = gcd_pkg::GCD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_a,
  input  logic [W-1:0] load_b,
  input  logic         step,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] steps
);

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] steps_q, steps_d;

  // Operation counter sticks at all-ones instead of wrapping.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  // Next operand/step values: load wins, otherwise one reduction step.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    steps_d = steps_q;
    if (load) begin
      a_d     = load_a;
      b_d     = load_b;
      steps_d = '0;
    end else if (step) begin
      if (a_q < b_q) begin
        a_d     = b_q;
        b_d     = a_q;
        steps_d = sat_inc(steps_q);
      end else if (b_q != '0) begin
        a_d     = a_q - b_q;
        steps_d = sat_inc(steps_q);
      end
    end
  end

  // Operand and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      steps_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      steps_q <= steps_d;
    end
  end

  // With B zero, A<B cannot hold, so no further action is possible: A is the GCD.
  assign done   = (b_q == '0);
  assign result = a_q;
  assign steps  = steps_q;

endmodule

// File: rtl/gcd_sched.sv
// Round-robin front end sharing one GCD datapath among N requesters, one job at a time.
module gcd_sched #(
  parameter int W = gcd_pkg::GCD_W,
  parameter int N = gcd_pkg::GCD_N
) (
  input  logic       clk,
  input  logic       rst_n,
  gcd_sched_if.slave bus,
  output logic       busy
);
  import gcd_pkg::*;

  localparam int IW = idx_w(N);

  state_e        state_q, state_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] id_q, id_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_gcd_q, rsp_gcd_d;
  logic [IW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]  rsp_steps_q, rsp_steps_d;

  logic          gnt_found;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] cand;
  logic [N-1:0]  ready;

  logic          core_load;
  logic          core_step;
  logic          core_done;
  logic [W-1:0]  core_result;
  logic [W-1:0]  core_steps;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int j = 1; j <= N; j++) begin
      cand = IW'((int'(last_grant_q) + j) % N);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Accept is only offered in IDLE, and never while reset is asserted.
  always_comb begin
    ready = '0;
    if (rst_n && (state_q == IDLE) && gnt_found) ready[gnt_idx] = 1'b1;
  end

  // Control: grant, run the core until it reports done, then hold the response.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_gcd_d    = rsp_gcd_q;
    rsp_id_d     = rsp_id_q;
    rsp_steps_d  = rsp_steps_q;
    core_load    = 1'b0;
    core_step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          core_load    = 1'b1;
          last_grant_d = gnt_idx;
          id_d         = gnt_idx;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (core_done) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_gcd_d   = core_result;
          rsp_id_d    = id_q;
          rsp_steps_d = core_steps;
        end else begin
          core_step = 1'b1;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, arbiter pointer and response registers; reset discards any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(N - 1);
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_gcd_q    <= '0;
      rsp_id_q     <= '0;
      rsp_steps_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_gcd_q    <= rsp_gcd_d;
      rsp_id_q     <= rsp_id_d;
      rsp_steps_q  <= rsp_steps_d;
    end
  end

  gcd_core #(.W(W)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (core_load),
    .load_a (bus.req_a[int'(gnt_idx)*W +: W]),
    .load_b (bus.req_b[int'(gnt_idx)*W +: W]),
    .step   (core_step),
    .done   (core_done),
    .result (core_result),
    .steps  (core_steps)
  );

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_gcd   = rsp_gcd_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_steps = rsp_steps_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_gcd_sched.sv
// Bench for gcd_sched: directed table, hand sequences and randomized jobs vs. a reference model.
module tb_gcd_sched;
  import gcd_pkg::*;

  localparam int W = 16;
  localparam int N = 4;
  localparam int MAXV = 65535;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  gcd_sched_if #(.W(W), .N(N)) bus ();

  gcd_sched #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int last_m = N - 1;
  int opa[N];
  int opb[N];
  logic [N-1:0] pend_mask = '0;
  int prev_gcd = 0;
  int prev_id = 0;
  int prev_steps = 0;

  typedef struct {
    int r;
    int a;
    int b;
    int e_gcd;
    int e_steps;
    int e_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Greatest common divisor by Euclid's remainder method.
  function automatic int ref_gcd(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Count of swap/subtract operations, grouping repeated subtractions by division.
  function automatic int ref_ops(input int a, input int b);
    int x, y, t, n;
    x = a;
    y = b;
    n = 0;
    if (x < y) begin
      t = x; x = y; y = t; n++;
    end
    while (y != 0) begin
      n += x / y;
      x = x % y;
      t = x; x = y; y = t; n++;
    end
    return n;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int j = 1; j <= N; j++) begin
      if (m[(last + j) % N]) return (last + j) % N;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = W'(opa[i]);
      bus.req_b[i*W +: W] = W'(opb[i]);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = '1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_gcd", bus.rsp_gcd, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_steps", bus.rsp_steps, 0);
    @(negedge clk);
    #1;
    chk("rst_req_ready_held", bus.req_ready, 0);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;
    last_m = N - 1;
    prev_gcd = 0;
    prev_id = 0;
    prev_steps = 0;
  endtask

  // One job from handshake to accepted response, checked against the model.
  task automatic do_job(input logic [N-1:0] mask, input int stall, input bit keep,
                        output int g, output int gcd_o, output int steps_o, output int lat_o);
    int exp_g, a, b, e_ops, e_steps, cnt;
    bit bad;
    logic [W-1:0] h_gcd, h_steps;
    logic [1:0] h_id;
    g = -1;
    gcd_o = -1;
    steps_o = -1;
    lat_o = -1;
    exp_g = rr_pick(mask, last_m);
    @(negedge clk);
    drive_ops();
    bus.req_valid = mask;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_rsp_valid", bus.rsp_valid, 0);
    chk("hold_gcd", bus.rsp_gcd, prev_gcd);
    chk("hold_id", bus.rsp_id, prev_id);
    chk("hold_steps", bus.rsp_steps, prev_steps);
    chk("grant_onehot", bus.req_ready, 64'(1) << exp_g);
    for (int i = N - 1; i >= 0; i--) if (bus.req_ready[i]) g = i;
    if (g < 0) begin
      bus.req_valid = '0;
      return;
    end
    last_m = exp_g;
    a = opa[exp_g];
    b = opb[exp_g];
    e_ops = ref_ops(a, b);
    e_steps = (e_ops > MAXV) ? MAXV : e_ops;
    @(negedge clk);
    if (!keep) bus.req_valid = pend_mask;
    bus.rsp_ready = (stall == 0);
    cnt = 1;
    bad = 1'b0;
    #1;
    while (!bus.rsp_valid && cnt < 70000) begin
      if (bus.req_ready !== '0 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
      cnt++;
      #1;
    end
    chk("run_ready_busy", bad, 0);
    chk("rsp_valid_seen", bus.rsp_valid, 1);
    if (bus.rsp_valid !== 1'b1) begin
      bus.rsp_ready = 1'b1;
      return;
    end
    lat_o = cnt;
    gcd_o = int'(bus.rsp_gcd);
    steps_o = int'(bus.rsp_steps);
    chk("latency", cnt, e_ops + 2);
    chk("rsp_gcd", bus.rsp_gcd, ref_gcd(a, b));
    chk("rsp_id", bus.rsp_id, exp_g);
    chk("rsp_steps", bus.rsp_steps, e_steps);
    h_gcd = bus.rsp_gcd;
    h_id = bus.rsp_id;
    h_steps = bus.rsp_steps;
    if (stall > 0) begin
      bad = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        #1;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_gcd !== h_gcd || bus.rsp_id !== h_id ||
            bus.rsp_steps !== h_steps || bus.req_ready !== '0 || busy !== 1'b1) bad = 1'b1;
      end
      chk("done_stall_stable", bad, 0);
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      #1;
    end
    prev_gcd = int'(h_gcd);
    prev_id = int'(h_id);
    prev_steps = int'(h_steps);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, gv, sv, lv;
    bit seen;
    int rr_exp[5];
    logic [N-1:0] m;

    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      opa[i] = 0;
      opb[i] = 0;
    end

    vecs[0] = '{r: 0, a: 12,    b: 8, e_gcd: 4, e_steps: 5,     e_lat: 7};
    vecs[1] = '{r: 1, a: 0,     b: 0, e_gcd: 0, e_steps: 0,     e_lat: 2};
    vecs[2] = '{r: 2, a: 0,     b: 5, e_gcd: 5, e_steps: 1,     e_lat: 3};
    vecs[3] = '{r: 3, a: 7,     b: 0, e_gcd: 7, e_steps: 0,     e_lat: 2};
    vecs[4] = '{r: 1, a: 9,     b: 6, e_gcd: 3, e_steps: 5,     e_lat: 7};
    vecs[5] = '{r: 0, a: 65535, b: 1, e_gcd: 1, e_steps: 65535, e_lat: 65538};

    apply_reset();

    // Directed single-requester vectors
    for (int k = 0; k < 6; k++) begin
      opa[vecs[k].r] = vecs[k].a;
      opb[vecs[k].r] = vecs[k].b;
      m = '0;
      m[vecs[k].r] = 1'b1;
      do_job(m, 0, 1'b0, g, gv, sv, lv);
      chk("tbl_id", g, vecs[k].r);
      chk("tbl_gcd", gv, vecs[k].e_gcd);
      chk("tbl_steps", sv, vecs[k].e_steps);
      chk("tbl_latency", lv, vecs[k].e_lat);
    end

    // Response held back for ten cycles while another request waits
    opa[1] = 12; opb[1] = 8;
    opa[3] = 21; opb[3] = 14;
    pend_mask = 4'b1000;
    do_job(4'b0010, 10, 1'b0, g, gv, sv, lv);
    chk("stall_gcd", gv, 4);
    pend_mask = '0;
    do_job(4'b1000, 0, 1'b0, g, gv, sv, lv);
    chk("after_stall_id", g, 3);
    chk("after_stall_gcd", gv, 7);

    // All requesters continuously valid: round-robin order from reset
    apply_reset();
    for (int i = 0; i < N; i++) begin
      opa[i] = 10 * (i + 1);
      opb[i] = 4 * (i + 1);
    end
    rr_exp = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      do_job(4'b1111, 0, 1'b1, g, gv, sv, lv);
      chk("rr_order", g, rr_exp[k]);
      chk("rr_gcd", gv, 2 * (rr_exp[k] + 1));
    end
    @(negedge clk);
    bus.req_valid = '0;

    // Reset in the middle of a long job
    opa[0] = 1000; opb[0] = 3;
    @(negedge clk);
    drive_ops();
    bus.req_valid = 4'b0001;
    #1;
    chk("mr_grant", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (20) @(negedge clk);
    #1;
    chk("mr_busy_before", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 4'b0100;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_rsp_valid", bus.rsp_valid, 0);
    chk("mr_req_ready", bus.req_ready, 0);
    chk("mr_rsp_gcd", bus.rsp_gcd, 0);
    chk("mr_rsp_steps", bus.rsp_steps, 0);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;
    last_m = N - 1;
    prev_gcd = 0;
    prev_id = 0;
    prev_steps = 0;
    seen = 1'b0;
    repeat (400) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("mr_no_stale_rsp", seen, 0);
    opa[2] = 9; opb[2] = 6;
    do_job(4'b0100, 0, 1'b0, g, gv, sv, lv);
    chk("mr_next_id", g, 2);
    chk("mr_next_gcd", gv, 3);

    // Randomized jobs with random requester sets and response back-pressure
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        opa[i] = int'($urandom_range(0, 127));
        opb[i] = int'($urandom_range(0, 127));
      end
      m = N'($urandom_range(1, 15));
      do_job(m, int'($urandom_range(0, 3)), 1'b0, g, gv, sv, lv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
